// File: rtl/ls_mem_unit.sv
// ls_mem_unit: in-order lw/sw execution stage with a request FIFO and an internal word memory.
// Latency: transfer to completion broadcast is LATENCY+1 cycles when empty; one op per LATENCY+1 cycles.
// Backpressure: req_ready drops while DEPTH requests are queued; unsupported ops are accepted and dropped.
module ls_mem_unit #(
   parameter int DEPTH     = 4,
   parameter int LATENCY   = 3,
   parameter int MEM_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_op,
   input  logic [31:0] req_address,
   input  logic [4:0]  req_reg,
   input  logic [31:0] req_data,
   output logic [63:0] out_databus,
   output logic        write_databus,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [31:0]      OP_LW    = 32'd9;
   localparam logic [31:0]      OP_SW    = 32'd10;
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // Request queue: one slot per field, indexed by the shared pointers
   logic              fifo_sw   [DEPTH];
   logic [31:0]       fifo_addr [DEPTH];
   logic [4:0]        fifo_reg  [DEPTH];
   logic [31:0]       fifo_data [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   // Data memory is never reset; it only starts out zeroed
   logic [31:0]       mem [MEM_WORDS] = '{default: 32'h0};

   // Operation currently being executed
   state_t            state;
   logic [LAT_W-1:0]  lat_cnt;
   logic              cur_sw;
   logic [31:0]       cur_addr;
   logic [4:0]        cur_reg;
   logic [31:0]       cur_data;
   logic [IDX_W-1:0]  cur_idx;

   logic              op_ok;
   logic              push;
   logic              pop;
   logic              access_end;

   assign op_ok      = (req_op == OP_LW) || (req_op == OP_SW);
   assign req_ready  = (count != FULL_CNT);
   // Unsupported ops still complete the handshake but never enter the queue
   assign push       = req_valid && req_ready && op_ok;
   assign pop        = (count != '0) && ((state == IDLE) || (state == DONE));
   assign access_end = (state == ACCESS) && (lat_cnt == '0);
   // Byte offset and bits above the memory index do not take part in the access
   assign cur_idx    = cur_addr[IDX_W+1:2];
   assign busy       = (state != IDLE) || (count != '0);

   // Queue pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue payload storage, written only on an accepted lw/sw
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_sw[wr_ptr]   <= (req_op == OP_SW);
         fifo_addr[wr_ptr] <= req_address;
         fifo_reg[wr_ptr]  <= req_reg;
         fifo_data[wr_ptr] <= req_data;
      end
   end

   // Store commit on the final access cycle; reset state keeps the FSM out of ACCESS
   always_ff @(posedge clock) begin
      if (access_end && cur_sw && !reset) begin
         mem[cur_idx] <= cur_data;
      end
   end

   // Execution FSM with registered broadcast; outputs fall back to zero outside DONE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         lat_cnt       <= '0;
         cur_sw        <= 1'b0;
         cur_addr      <= '0;
         cur_reg       <= '0;
         cur_data      <= '0;
         out_databus   <= '0;
         write_databus <= 1'b0;
         wb_valid      <= 1'b0;
         wb_reg        <= '0;
         wb_data       <= '0;
      end else begin
         out_databus   <= '0;
         write_databus <= 1'b0;
         wb_valid      <= 1'b0;
         wb_reg        <= '0;
         wb_data       <= '0;
         case (state)
            IDLE, DONE: begin
               if (pop) begin
                  state    <= ACCESS;
                  lat_cnt  <= LAT_INIT;
                  cur_sw   <= fifo_sw[rd_ptr];
                  cur_addr <= fifo_addr[rd_ptr];
                  cur_reg  <= fifo_reg[rd_ptr];
                  cur_data <= fifo_data[rd_ptr];
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end else begin
                  state         <= DONE;
                  write_databus <= 1'b1;
                  out_databus   <= {(cur_sw ? 16'h0002 : 16'h0001), 16'h0000, cur_addr};
                  if (!cur_sw) begin
                     wb_valid <= 1'b1;
                     wb_reg   <= cur_reg;
                     wb_data  <= mem[cur_idx];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ls_mem_unit.sv
// tb_ls_mem_unit: directed vectors for ls_mem_unit with hand-computed expected results.
// Broadcasts are captured by a negedge monitor and compared against constant expectations.
// Every wait is bounded so the bench always reaches its summary line.
`timescale 1ns/1ps
module tb_ls_mem_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_op = '0;
   logic [31:0] req_address = '0;
   logic [4:0]  req_reg = '0;
   logic [31:0] req_data = '0;
   logic [63:0] out_databus;
   logic        write_databus;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        busy;

   typedef struct {
      logic [63:0] bus;
      logic        wbv;
      logic [4:0]  r;
      logic [31:0] d;
      int          t;
   } ev_t;

   ev_t evq[$];
   int  cyc = 0;
   int  viol = 0;
   int  vectors = 0;
   int  miscompares = 0;

   ls_mem_unit #(.DEPTH(4), .LATENCY(3), .MEM_WORDS(256)) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_address   (req_address),
      .req_reg       (req_reg),
      .req_data      (req_data),
      .out_databus   (out_databus),
      .write_databus (write_databus),
      .wb_valid      (wb_valid),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Capture every broadcast with the index of the edge that produced it
   always @(negedge clock) begin
      ev_t e;
      if (write_databus) begin
         e.bus = out_databus;
         e.wbv = wb_valid;
         e.r   = wb_reg;
         e.d   = wb_data;
         e.t   = cyc;
         evq.push_back(e);
      end else if (out_databus != 64'h0 || wb_valid) begin
         viol++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one request from a negedge; returns the transfer edge index and cycles stalled
   task automatic send(input logic [31:0] op, input logic [31:0] addr, input logic [4:0] r,
                       input logic [31:0] d, output int t, output int waited);
      waited      = 0;
      t           = cyc;
      req_valid   = 1'b1;
      req_op      = op;
      req_address = addr;
      req_reg     = r;
      req_data    = d;
      while (!req_ready && waited < 40) begin
         @(negedge clock);
         waited++;
      end
      if (!req_ready) begin
         chk("send_timeout", req_ready, 1);
      end else begin
         @(posedge clock);
         @(negedge clock);
         t = cyc;
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_ev(input int n);
      int g = 0;
      while (evq.size() < n && g < 60) begin
         @(negedge clock);
         g++;
      end
      if (evq.size() < n) chk("ev_timeout", evq.size(), n);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 60) begin
         @(negedge clock);
         g++;
      end
      if (busy) chk("idle_timeout", busy, 0);
      @(negedge clock);
   endtask

   initial begin
      int t, t2, w, tp, base;
      int tr[5];
      logic [31:0] ea;

      // Reset and idle state
      repeat (3) @(negedge clock);
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_bus", out_databus, 64'h0);
      chk("rst_write", write_databus, 0);
      chk("rst_wbv", wb_valid, 0);
      chk("rst_wbdata", wb_data, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle_ready", req_ready, 1);
      chk("idle_busy", busy, 0);

      // sw 0x40 <- DEADBEEF
      send(32'd10, 32'h40, 5'd0, 32'hDEADBEEF, t, w);
      chk("sw_busy", busy, 1);
      wait_ev(1);
      chk("sw_lat", evq[0].t - t, 4);
      chk("sw_bus", evq[0].bus, 64'h0002_0000_0000_0040);
      chk("sw_wbv", evq[0].wbv, 0);
      wait_idle();

      // lw 0x40 -> r7
      send(32'd9, 32'h40, 5'd7, 32'h0, t, w);
      wait_ev(2);
      chk("lw_lat", evq[1].t - t, 4);
      chk("lw_bus", evq[1].bus, 64'h0001_0000_0000_0040);
      chk("lw_wbv", evq[1].wbv, 1);
      chk("lw_reg", evq[1].r, 5'd7);
      chk("lw_data", evq[1].d, 32'hDEADBEEF);
      wait_idle();
      chk("lw_pulse_count", evq.size(), 2);
      chk("lw_bus_clear", out_databus, 64'h0);

      // One lw in flight, then five back-to-back lw fill the queue
      base = evq.size();
      send(32'd9, 32'h40, 5'd1, 32'h0, tp, w);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("full_ready", req_ready, 0);
         send(32'd9, 32'h200 + 32'(4 * i), 5'(2 + i), 32'h0, tr[i], w);
         chk(i < 4 ? "burst_wait" : "full_wait", w, (i < 4) ? 0 : 1);
      end
      chk("r4_edge", tr[4] - tr[3], 2);
      wait_ev(base + 6);
      for (int k = 0; k < 6; k++) begin
         ea = (k == 0) ? 32'h40 : 32'h200 + 32'(4 * (k - 1));
         chk("burst_bus", evq[base + k].bus, {16'h0001, 16'h0000, ea});
         chk("burst_wbv", evq[base + k].wbv, 1);
         chk("burst_reg", evq[base + k].r, 5'(k + 1));
         chk("burst_data", evq[base + k].d, (k == 0) ? 32'hDEADBEEF : 32'h0);
         chk("burst_gap", evq[base + k].t - ((k == 0) ? tp : evq[base + k - 1].t), 4);
      end

      // Unsupported op is accepted and dropped
      wait_idle();
      base = evq.size();
      send(32'd3, 32'h40, 5'd9, 32'h1, t, w);
      chk("bad_op_wait", w, 0);
      chk("bad_op_busy", busy, 0);
      chk("bad_op_ready", req_ready, 1);
      repeat (8) @(negedge clock);
      chk("bad_op_nobcast", evq.size(), base);

      // Reset while a sw is in ACCESS
      send(32'd10, 32'h80, 5'd0, 32'h5, t, w);
      @(negedge clock);
      chk("mid_busy", busy, 1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_bus", out_databus, 64'h0);
      @(negedge clock);
      reset = 1'b0;
      repeat (8) @(negedge clock);
      chk("mid_rst_nobcast", evq.size(), base);
      send(32'd9, 32'h80, 5'd3, 32'h0, t, w);
      wait_ev(base + 1);
      chk("mid_lw_bus", evq[base].bus, 64'h0001_0000_0000_0080);
      chk("mid_lw_wbv", evq[base].wbv, 1);
      chk("mid_lw_data", evq[base].d, 32'h0);
      chk("mid_lw_lat", evq[base].t - t, 4);

      // Address aliasing: high bits and byte offset ignored, full address echoed
      wait_idle();
      base = evq.size();
      send(32'd10, 32'h1234_0104, 5'd0, 32'hCAFEF00D, t, w);
      send(32'd9, 32'h0000_0107, 5'd31, 32'h0, t2, w);
      wait_ev(base + 2);
      chk("alias_sw_bus", evq[base].bus, 64'h0002_0000_1234_0104);
      chk("alias_lw_bus", evq[base + 1].bus, 64'h0001_0000_0000_0107);
      chk("alias_lw_reg", evq[base + 1].r, 5'd31);
      chk("alias_lw_data", evq[base + 1].d, 32'hCAFEF00D);
      chk("alias_gap", evq[base + 1].t - evq[base].t, 4);

      wait_idle();
      repeat (2) @(negedge clock);
      chk("total_bcasts", evq.size(), 11);
      chk("stale_bus", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
